// File: rtl/pll_hs_lock_ctrl.sv
// Reset/lock sequencer for the DSI HS-clock PLL: pulses pll_rst, qualifies pll_lock, re-phases dividers, releases HS reset.
// Optional lock-wait timeout with retry counting is enabled by defining PLL_LOCK_TIMEOUT_EN.
module pll_hs_lock_ctrl #(
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_STABLE    = 1024,
    parameter int RSTODIV_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clkin1,
    input  logic       ext_rst,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       rstodiv,
    output logic       clk_hs_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic [2:0] retry_cnt
);

    localparam int RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int STAB_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam int ODIV_W = (RSTODIV_CYCLES > 1) ? $clog2(RSTODIV_CYCLES) : 1;

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
    localparam logic [ODIV_W-1:0] ODIV_LAST = ODIV_W'(RSTODIV_CYCLES - 1);

    if (RST_CYCLES < 2 || LOCK_STABLE < 2 || RSTODIV_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("pll_hs_lock_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_WAIT = 2'd1,
        S_ODIV = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               sync_q;
    logic               lock_s;
    logic [RST_W-1:0]   rst_cnt;
    logic [STAB_W-1:0]  stab_cnt;
    logic [ODIV_W-1:0]  odiv_cnt;
    logic               timeout_hit;
    logic               pll_rst_d;
    logic               rstodiv_d;
    logic               clk_hs_rst_d;
    logic               ready_d;
    logic               lock_lost_d;

    // pll_lock comes from the PLL's own analog domain; two flops before any decision.
    always_ff @(posedge clkin1 or posedge ext_rst) begin
        if (ext_rst) begin
            sync_q <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync_q <= pll_lock;
            lock_s <= sync_q;
        end
    end

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clkin1 or posedge ext_rst) begin
        if (ext_rst) begin
            to_cnt    <= '0;
            retry_cnt <= 3'd0;
        end else begin
            if (state_d != state_q) to_cnt <= '0;
            else if (state_q == S_WAIT) to_cnt <= to_cnt + 1'b1;
            // Only a WAIT->RST exit is a timeout; stable-lock completion takes priority in state_d.
            if (state_q == S_WAIT && state_d == S_RST && retry_cnt != 3'd7)
                retry_cnt <= retry_cnt + 3'd1;
        end
    end

    assign timeout_hit = (to_cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
    assign retry_cnt   = 3'd0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  if (rst_cnt == RST_LAST) state_d = S_WAIT;
            S_WAIT: begin
                if (lock_s && stab_cnt == STAB_LAST) state_d = S_ODIV;
                else if (timeout_hit)                state_d = S_RST;
            end
            S_ODIV: begin
                if (!lock_s)                    state_d = S_RST;
                else if (odiv_cnt == ODIV_LAST) state_d = S_RUN;
            end
            S_RUN:  if (!lock_s) state_d = S_RST;
            default: state_d = S_RST;
        endcase

        // Outputs are decoded from the next state so they register on the same edge as state_q.
        pll_rst_d    = (state_d == S_RST);
        rstodiv_d    = (state_d == S_ODIV);
        clk_hs_rst_d = (state_d != S_RUN);
        ready_d      = (state_d == S_RUN);
        lock_lost_d  = lock_lost | (state_q == S_RUN && !lock_s);
    end

    always_ff @(posedge clkin1 or posedge ext_rst) begin
        if (ext_rst) begin
            state_q    <= S_RST;
            pll_rst    <= 1'b1;
            rstodiv    <= 1'b0;
            clk_hs_rst <= 1'b1;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pll_rst    <= pll_rst_d;
            rstodiv    <= rstodiv_d;
            clk_hs_rst <= clk_hs_rst_d;
            ready      <= ready_d;
            lock_lost  <= lock_lost_d;
        end
    end

    always_ff @(posedge clkin1 or posedge ext_rst) begin
        if (ext_rst) begin
            rst_cnt  <= '0;
            stab_cnt <= '0;
            odiv_cnt <= '0;
        end else if (state_d != state_q) begin
            rst_cnt  <= '0;
            stab_cnt <= '0;
            odiv_cnt <= '0;
        end else begin
            case (state_q)
                S_RST:   rst_cnt  <= rst_cnt + 1'b1;
                S_WAIT:  stab_cnt <= lock_s ? stab_cnt + 1'b1 : '0;
                S_ODIV:  odiv_cnt <= odiv_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_hs_lock_ctrl.sv
// Bench for pll_hs_lock_ctrl: output transitions are predicted as (signal, value, cycle) events and checked in order.
// With PLL_LOCK_TIMEOUT_EN defined the last scenario exercises the timeout/retry path instead of the endless wait.
module tb_pll_hs_lock_ctrl;

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int TO = 200;
`else
    localparam int TO = 65000;
`endif

    localparam int ID_PLL_RST  = 0;
    localparam int ID_RSTODIV  = 1;
    localparam int ID_HS_RST   = 2;
    localparam int ID_READY    = 3;
    localparam int ID_LOST     = 4;

    logic       clkin1 = 1'b0;
    logic       ext_rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_rst;
    logic       rstodiv;
    logic       clk_hs_rst;
    logic       ready;
    logic       lock_lost;
    logic [2:0] retry_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];
    logic [4:0]  prev_out = 5'b00111;

    pll_hs_lock_ctrl #(
        .RST_CYCLES(16),
        .LOCK_STABLE(1024),
        .RSTODIV_CYCLES(4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clkin1(clkin1),
        .ext_rst(ext_rst),
        .pll_lock(pll_lock),
        .pll_rst(pll_rst),
        .rstodiv(rstodiv),
        .clk_hs_rst(clk_hs_rst),
        .ready(ready),
        .lock_lost(lock_lost),
        .retry_cnt(retry_cnt)
    );

    // clock / cycle counter: cycle 0 is the period in which ext_rst is released
    always #5 clkin1 = ~clkin1;

    always @(posedge clkin1) begin
        if (ext_rst) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] evt(input int id, input logic v, input int c);
        return 32'(id) * 32'h0100_0000 + 32'(v) * 32'h0010_0000 + 32'(c);
    endfunction

    task automatic push_evt(input int id, input logic v, input int c);
        exp_q.push_back(evt(id, v, c));
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clkin1);
            #1;
        end
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clkin1);
        #2;
        ext_rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_pll_rst"},    32'(pll_rst),    32'd1);
        check_eq({tag, "_rstodiv"},    32'(rstodiv),    32'd0);
        check_eq({tag, "_clk_hs_rst"}, 32'(clk_hs_rst), 32'd1);
        check_eq({tag, "_ready"},      32'(ready),      32'd0);
        check_eq({tag, "_lock_lost"},  32'(lock_lost),  32'd0);
        check_eq({tag, "_retry_cnt"},  32'(retry_cnt),  32'd0);
    endtask

    // scoreboard: every output edge outside reset must match the next predicted event
    always @(negedge clkin1) begin
        logic [4:0] cur;
        cur = {lock_lost, ready, clk_hs_rst, rstodiv, pll_rst};
        if (!ext_rst) begin
            for (int i = 0; i < 5; i++) begin
                if (cur[i] != prev_out[i]) begin
                    if (exp_q.size() == 0) check_eq("evt_unexpected", evt(i, cur[i], cyc), 32'hffff_ffff);
                    else                   check_eq("evt", evt(i, cur[i], cyc), exp_q.pop_front());
                end
            end
        end
        prev_out = cur;
    end

    initial begin
        // reset state
        repeat (3) @(posedge clkin1);
        #2;
        check_reset_values("rst");
        ext_rst = 1'b0;

        // nominal bring-up, pll_lock rises in cycle 30 -> lock_s in 32
        push_evt(ID_PLL_RST, 1'b0, 16);
        push_evt(ID_RSTODIV, 1'b1, 32 + 1024);
        push_evt(ID_RSTODIV, 1'b0, 32 + 1028);
        push_evt(ID_HS_RST,  1'b0, 32 + 1028);
        push_evt(ID_READY,   1'b1, 32 + 1028);
        wait_cyc(30);
        pll_lock = 1'b1;
        wait_cyc(1070);
        check_eq("nominal_ready", 32'(ready), 32'd1);

        // loss of lock in RUN for two cycles starting at cycle 1100
        wait_cyc(1100);
        push_evt(ID_PLL_RST, 1'b1, 1103);
        push_evt(ID_HS_RST,  1'b1, 1103);
        push_evt(ID_READY,   1'b0, 1103);
        push_evt(ID_LOST,    1'b1, 1103);
        push_evt(ID_PLL_RST, 1'b0, 1103 + 16);
        push_evt(ID_RSTODIV, 1'b1, 1119 + 1024);
        push_evt(ID_RSTODIV, 1'b0, 1119 + 1028);
        push_evt(ID_HS_RST,  1'b0, 1119 + 1028);
        push_evt(ID_READY,   1'b1, 1119 + 1028);
        pll_lock = 1'b0;
        wait_cyc(1102);
        pll_lock = 1'b1;
        wait_cyc(2160);
        check_eq("relock_ready", 32'(ready), 32'd1);
        check_eq("relock_lost_sticky", 32'(lock_lost), 32'd1);

        // asynchronous reset mid-RUN, checked before the next clock edge
        wait_cyc(2200);
        #1;
        ext_rst = 1'b1;
        #1;
        check_reset_values("async");
        release_reset();

        // lock glitch while waiting: stability count restarts after it
        push_evt(ID_PLL_RST, 1'b0, 16);
        push_evt(ID_RSTODIV, 1'b1, 521 + 1024);
        push_evt(ID_RSTODIV, 1'b0, 521 + 1028);
        push_evt(ID_HS_RST,  1'b0, 521 + 1028);
        push_evt(ID_READY,   1'b1, 521 + 1028);
        wait_cyc(516);
        pll_lock = 1'b0;
        wait_cyc(519);
        pll_lock = 1'b1;
        wait_cyc(1540);
        check_eq("glitch_not_ready_yet", 32'(ready), 32'd0);
        wait_cyc(1560);
        check_eq("glitch_ready", 32'(ready), 32'd1);

        // lock never arrives
        wait_cyc(1600);
        ext_rst = 1'b1;
        pll_lock = 1'b0;
        release_reset();
        push_evt(ID_PLL_RST, 1'b0, 16);
`ifdef PLL_LOCK_TIMEOUT_EN
        for (int k = 1; k <= 9; k++) begin
            push_evt(ID_PLL_RST, 1'b1, 216 * k);
            push_evt(ID_PLL_RST, 1'b0, 216 * k + 16);
        end
        for (int k = 1; k <= 9; k++) begin
            wait_cyc(216 * k + 1);
            check_eq("retry_cnt", 32'(retry_cnt), 32'((k > 7) ? 7 : k));
        end
        wait_cyc(216 * 9 + 20);
        check_eq("timeout_ready", 32'(ready), 32'd0);
`else
        wait_cyc(3000);
        check_eq("nolock_pll_rst", 32'(pll_rst), 32'd0);
        check_eq("nolock_retry_cnt", 32'(retry_cnt), 32'd0);
        check_eq("nolock_ready", 32'(ready), 32'd0);
        check_eq("nolock_clk_hs_rst", 32'(clk_hs_rst), 32'd1);
`endif

        check_eq("events_pending", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
